// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control codes, result-select
// codes and the immediate-format selector used by the decode stage.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_cycle_if.sv
// Bundle of the IF/ID inputs, write-back port and ID/EX outputs of the
// decode stage; slave = decode stage, master = surrounding pipeline.
interface decode_cycle_if;
  import riscv_pkg::*;

  logic [XLEN-1:0]       InstrD;
  logic [XLEN-1:0]       PCD;
  logic [XLEN-1:0]       PCPlus4D;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       ResultW;
  logic                  FlushE;

  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic                  RegWriteE;
  logic [1:0]            ResultSrcE;
  logic                  MemWriteE;
  logic                  JumpE;
  logic                  BranchE;
  logic [2:0]            ALUControlE;
  logic                  ALUSrcE;
  logic                  IllegalE;
  logic [XLEN-1:0]       RD1E;
  logic [XLEN-1:0]       RD2E;
  logic [XLEN-1:0]       ImmExtE;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [XLEN-1:0]       PCE;
  logic [XLEN-1:0]       PCPlus4E;

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
           ALUControlE, ALUSrcE, IllegalE, RD1E, RD2E, ImmExtE,
           Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
           ALUControlE, ALUSrcE, IllegalE, RD1E, RD2E, ImmExtE,
           Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );

endinterface

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: one write port from write-back, two combinational
// read ports, x0 hardwired to zero. REGFILE_BYPASS_EN enables write-first reads.
module register_file
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2
);

  logic [XLEN-1:0] regs [2**REG_ADDR_W];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-first: a same-cycle write to the addressed register wins.
  assign rd1 = (ra1 == '0) ? '0 : (wr_en && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (wr_en && wa == ra2) ? wd : regs[ra2];
`else
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`endif

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, register read and
// the ID/EX pipeline register. Optional macro: REGFILE_BYPASS_EN.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [1:0]      alu_op;
  logic            illegal_op;
  logic            illegal_funct;
  imm_src_t        imm_src;
  ctrl_t           ctrl_main;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_e;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  assign opcode    = bus.InstrD[6:0];
  assign funct3    = bus.InstrD[14:12];
  assign funct7b5  = bus.InstrD[30];
  assign bus.Rs1D  = bus.InstrD[19:15];
  assign bus.Rs2D  = bus.InstrD[24:20];

  always_comb begin
    ctrl_main  = '0;
    imm_src    = IMM_I;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl_main.reg_write  = 1'b1;
        ctrl_main.alu_src    = 1'b1;
        ctrl_main.result_src = RES_MEM;
      end
      OP_SW: begin
        imm_src             = IMM_S;
        ctrl_main.alu_src   = 1'b1;
        ctrl_main.mem_write = 1'b1;
      end
      OP_R: begin
        ctrl_main.reg_write = 1'b1;
        alu_op              = 2'b10;
      end
      OP_I: begin
        ctrl_main.reg_write = 1'b1;
        ctrl_main.alu_src   = 1'b1;
        alu_op              = 2'b10;
      end
      OP_BEQ: begin
        imm_src          = IMM_B;
        ctrl_main.branch = 1'b1;
        alu_op           = 2'b01;
      end
      OP_JAL: begin
        imm_src              = IMM_J;
        ctrl_main.reg_write  = 1'b1;
        ctrl_main.result_src = RES_PC4;
        ctrl_main.jump       = 1'b1;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_d        = ctrl_main;
    illegal_funct = 1'b0;
    case (alu_op)
      2'b01:   ctrl_d.alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ctrl_d.alu_control = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl_d.alu_control = ALU_SLT;
          3'b110:  ctrl_d.alu_control = ALU_OR;
          3'b111:  ctrl_d.alu_control = ALU_AND;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: ctrl_d.alu_control = ALU_ADD;
    endcase
    // Unsupported encodings become a bubble that only carries the flag.
    if (illegal_op || illegal_funct) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
    end
  end

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
      IMM_S: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      IMM_B: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                        bus.InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                        bus.InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .we  (bus.RegWriteW),
    .wa  (bus.RdW),
    .wd  (bus.ResultW),
    .ra1 (bus.Rs1D),
    .ra2 (bus.Rs2D),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) begin
      ctrl_e       <= '0;
      bus.RD1E     <= '0;
      bus.RD2E     <= '0;
      bus.ImmExtE  <= '0;
      bus.Rs1E     <= '0;
      bus.Rs2E     <= '0;
      bus.RdE      <= '0;
      bus.PCE      <= '0;
      bus.PCPlus4E <= '0;
    end else begin
      ctrl_e       <= ctrl_d;
      bus.RD1E     <= rd1_d;
      bus.RD2E     <= rd2_d;
      bus.ImmExtE  <= imm_ext;
      bus.Rs1E     <= bus.Rs1D;
      bus.Rs2E     <= bus.Rs2D;
      bus.RdE      <= bus.InstrD[11:7];
      bus.PCE      <= bus.PCD;
      bus.PCPlus4E <= bus.PCPlus4D;
    end
  end

  assign bus.RegWriteE   = ctrl_e.reg_write;
  assign bus.ResultSrcE  = ctrl_e.result_src;
  assign bus.MemWriteE   = ctrl_e.mem_write;
  assign bus.JumpE       = ctrl_e.jump;
  assign bus.BranchE     = ctrl_e.branch;
  assign bus.ALUControlE = ctrl_e.alu_control;
  assign bus.ALUSrcE     = ctrl_e.alu_src;
  assign bus.IllegalE    = ctrl_e.illegal;

endmodule
